// File: rtl/filter_stim_pkg.sv
// Shared definitions for the filter stimulus generator: waveform mode codes,
// FSM state encoding and the 8-bit LFSR seed, taps and step function.
package filter_stim_pkg;

    typedef enum logic [2:0] {
        MODE_IMPULSE = 3'd0,
        MODE_STEP    = 3'd1,
        MODE_RAMP    = 3'd2,
        MODE_SQUARE  = 3'd3,
        MODE_NOISE   = 3'd4
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int unsigned        LFSR_W    = 8;
    localparam logic [LFSR_W-1:0]  LFSR_SEED = 8'h01;
    // x^8 + x^6 + x^5 + x^4 + 1 : feedback from bits 7, 5, 4, 3
    localparam logic [LFSR_W-1:0]  LFSR_TAPS = 8'hB8;

    // One Fibonacci step: shift left, feedback parity into bit 0.
    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
        return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/filter_stim_if.sv
// Control and sample-stream signals of the filter stimulus generator.
// master: controlling side (issues start/abort and configuration).
// slave:  the generator (drives the sample stream and status).
interface filter_stim_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned CNT_W  = 8
) ();
    logic              start_i;
    logic              abort_i;
    logic [2:0]        mode_i;
    logic [DATA_W-1:0] amp_i;
    logic [CNT_W-1:0]  period_i;
    logic [CNT_W-1:0]  div_i;
    logic [CNT_W-1:0]  len_i;
    logic [DATA_W-1:0] x_o;
    logic              valid_o;
    logic              busy_o;
    logic              done_o;

    modport master (
        output start_i, abort_i, mode_i, amp_i, period_i, div_i, len_i,
        input  x_o, valid_o, busy_o, done_o
    );

    modport slave (
        input  start_i, abort_i, mode_i, amp_i, period_i, div_i, len_i,
        output x_o, valid_o, busy_o, done_o
    );
endinterface

// File: rtl/filter_stim_lfsr.sv
// 8-bit Fibonacci LFSR for the noise waveform. load_i reseeds (priority),
// adv_i steps once; state_o is the current register value.
module filter_stim_lfsr
    import filter_stim_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic              adv_i,
    output logic [LFSR_W-1:0] state_o
);
    logic [LFSR_W-1:0] lfsr_q;
    logic [LFSR_W-1:0] lfsr_d;

    // Next LFSR value: reseed, step, or hold.
    always_comb begin
        lfsr_d = lfsr_q;
        if (load_i) begin
            lfsr_d = LFSR_SEED;
        end else if (adv_i) begin
            lfsr_d = lfsr_step(lfsr_q);
        end
    end

    // LFSR register, seeded on reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign state_o = lfsr_q;
endmodule

// File: rtl/filter_stim_gen.sv
// Programmable waveform source feeding the filter's 8-bit x input.
// Modes: impulse, step, ramp, square, LFSR noise; per-sample hold of div+1
// cycles; len samples per run (0 = 2^CNT_W).
// Optional macro FILTER_STIM_BIPOLAR_EN: square alternates +amp / -amp.
module filter_stim_gen
    import filter_stim_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned CNT_W  = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    filter_stim_if.slave bus
);
    state_e            state_q, state_d;
    logic [DATA_W-1:0] x_q, x_d;
    logic              valid_q, valid_d;
    logic [2:0]        mode_q, mode_d;
    logic [DATA_W-1:0] amp_q, amp_d;
    logic [CNT_W-1:0]  per_q, per_d;
    logic [CNT_W-1:0]  div_q, div_d;
    logic [CNT_W-1:0]  len_q, len_d;
    logic [CNT_W-1:0]  k_q, k_d;
    logic [CNT_W-1:0]  div_cnt_q, div_cnt_d;
    logic [CNT_W-1:0]  per_cnt_q, per_cnt_d;
    logic              phase_q, phase_d;
    logic [DATA_W-1:0] acc_q, acc_d;

    logic              lfsr_load;
    logic              lfsr_adv;
    logic [LFSR_W-1:0] lfsr_s;
    logic [DATA_W-1:0] acc_nx;
    logic [CNT_W-1:0]  per_last;
    logic [CNT_W-1:0]  k_last;
    logic              per_wrap;

    // Sample value from the per-sample generator state.
    function automatic logic [DATA_W-1:0] sample_val(
        input logic [2:0]        mode,
        input logic [DATA_W-1:0] amp,
        input logic [DATA_W-1:0] acc,
        input logic              phase,
        input logic [LFSR_W-1:0] lfsr,
        input logic              first
    );
        logic [DATA_W-1:0] v;
        v = '0;
        case (mode)
            MODE_IMPULSE: v = first ? amp : '0;
            MODE_STEP:    v = amp;
            MODE_RAMP:    v = acc;
`ifdef FILTER_STIM_BIPOLAR_EN
            MODE_SQUARE:  v = phase ? (~amp + DATA_W'(1)) : amp;
`else
            MODE_SQUARE:  v = phase ? '0 : amp;
`endif
            MODE_NOISE:   v = DATA_W'(lfsr);
            default:      v = '0;
        endcase
        return v;
    endfunction

    filter_stim_lfsr u_lfsr (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (lfsr_load),
        .adv_i   (lfsr_adv),
        .state_o (lfsr_s)
    );

    // The sample register always holds sample k, so the next sample is
    // computed from the stepped generator state (acc + amp, LFSR step).
    always_comb begin
        state_d   = state_q;
        x_d       = '0;
        valid_d   = 1'b0;
        mode_d    = mode_q;
        amp_d     = amp_q;
        per_d     = per_q;
        div_d     = div_q;
        len_d     = len_q;
        k_d       = k_q;
        div_cnt_d = div_cnt_q;
        per_cnt_d = per_cnt_q;
        phase_d   = phase_q;
        acc_d     = acc_q;
        lfsr_load = 1'b0;
        lfsr_adv  = 1'b0;
        acc_nx    = acc_q + amp_q;
        per_last  = (per_q == '0) ? '0 : per_q - CNT_W'(1);
        k_last    = len_q - CNT_W'(1);
        per_wrap  = (per_cnt_q == per_last);

        unique case (state_q)
            ST_IDLE: begin
                if (bus.start_i && !bus.abort_i) begin
                    mode_d    = bus.mode_i;
                    amp_d     = bus.amp_i;
                    per_d     = bus.period_i;
                    div_d     = bus.div_i;
                    len_d     = bus.len_i;
                    k_d       = '0;
                    div_cnt_d = '0;
                    per_cnt_d = '0;
                    phase_d   = 1'b0;
                    acc_d     = '0;
                    lfsr_load = 1'b1;
                    valid_d   = 1'b1;
                    x_d       = sample_val(bus.mode_i, bus.amp_i, '0, 1'b0, LFSR_SEED, 1'b1);
                    state_d   = ST_RUN;
                end
            end
            ST_RUN: begin
                if (bus.abort_i) begin
                    state_d = ST_IDLE;
                end else if (div_cnt_q != div_q) begin
                    div_cnt_d = div_cnt_q + CNT_W'(1);
                    x_d       = x_q;
                end else if (k_q == k_last) begin
                    state_d = ST_DONE;
                end else begin
                    k_d       = k_q + CNT_W'(1);
                    div_cnt_d = '0;
                    acc_d     = acc_nx;
                    per_cnt_d = per_wrap ? '0 : per_cnt_q + CNT_W'(1);
                    phase_d   = phase_q ^ per_wrap;
                    lfsr_adv  = 1'b1;
                    valid_d   = 1'b1;
                    x_d       = sample_val(mode_q, amp_q, acc_nx, phase_q ^ per_wrap,
                                           lfsr_step(lfsr_s), 1'b0);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, output and counter registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            x_q       <= '0;
            valid_q   <= 1'b0;
            mode_q    <= '0;
            amp_q     <= '0;
            per_q     <= '0;
            div_q     <= '0;
            len_q     <= '0;
            k_q       <= '0;
            div_cnt_q <= '0;
            per_cnt_q <= '0;
            phase_q   <= 1'b0;
            acc_q     <= '0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            valid_q   <= valid_d;
            mode_q    <= mode_d;
            amp_q     <= amp_d;
            per_q     <= per_d;
            div_q     <= div_d;
            len_q     <= len_d;
            k_q       <= k_d;
            div_cnt_q <= div_cnt_d;
            per_cnt_q <= per_cnt_d;
            phase_q   <= phase_d;
            acc_q     <= acc_d;
        end
    end

    assign bus.x_o     = x_q;
    assign bus.valid_o = valid_q;
    assign bus.busy_o  = (state_q == ST_RUN);
    assign bus.done_o  = (state_q == ST_DONE);
endmodule
